apb_multi_master: RTL
=====================

# apb_multi_master

Parametrised APB requester that converts a simple valid/ready request interface into APB transfers spread over `NUM_SLAVES` decoded slave selects. It supports:
- back-to-back transfers;
- write strobes;
- wait states;
- a wait-state timeout;
- decode-error and slave-error reporting.

It sits between the system-side command source and the APB slave fabric, and replaces the single-select IDLE/SETUP/ACCESS bridge.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `req_addr` and `paddr`.
- `DATA_WIDTH`, 32: data width. Must be 8, 16 or 32.
- `NUM_SLAVES`, 4: number of slave selects, 1..16.
- `SEL_LSB`, 12: lowest address bit of the slave index field. The field is `req_addr[SEL_LSB +: SW]`, with `SW = max(1, $clog2(NUM_SLAVES))`.
- `TIMEOUT`, 16: maximum ACCESS cycles before forced termination, 2..255.

Ports:
- `pclk` in 1: the only clock. All logic is on its rising edge.
- `preset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: transfer address.
- `req_wdata` in DATA_WIDTH: write data.
- `req_strb` in DATA_WIDTH/8: write byte strobes.
- `rsp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata` out DATA_WIDTH: read data. Held until the next `rsp_valid`.
- `rsp_err` out 1: completion error, qualified by `rsp_valid`.
- `psel` out NUM_SLAVES: one-hot slave select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB write.
- `paddr` out ADDR_WIDTH: APB address.
- `pwdata` out DATA_WIDTH: APB write data.
- `pstrb` out DATA_WIDTH/8: APB strobes. Forced to 0 on reads.
- `prdata` in NUM_SLAVES*DATA_WIDTH: per-slave read data. Slave i uses bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `pready` in NUM_SLAVES: per-slave ready.
- `pslverr` in NUM_SLAVES: per-slave error.

## Operation
- **States.** IDLE, SETUP, ACCESS, DECERR. Reset forces IDLE.
- **Reset values.** Reset forces `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, and the timeout counter to 0.
- **`req_ready`.**
  - Equals `!preset && (state==IDLE || (state==ACCESS && done))`.
  - `done` = the selected slave's `pready`, or the timeout counter equals `TIMEOUT-1`.
  - `req_ready` is combinational from `pready`.
- **Decode on accept.** `idx` = index field of `req_addr`.
  - If `idx < NUM_SLAVES`: latch `paddr`, `pwrite`, `pwdata`, `pstrb` and the one-hot select, then go to SETUP.
  - Otherwise: go to DECERR. No `psel` is asserted.
- **SETUP.** `psel[idx]`=1, `penable`=0. Always lasts exactly one cycle, then ACCESS.
- **ACCESS.** `psel[idx]`=1, `penable`=1. The counter increments each cycle and starts at 0 on ACCESS entry.
  - If `pready[idx]`=1: capture `prdata[idx]` into `rsp_rdata` (reads only; writes leave `rsp_rdata` unchanged). Set `rsp_err` = `pslverr[idx]` and pulse `rsp_valid` on the next cycle.
  - If the counter reaches `TIMEOUT-1` without `pready`: terminate with `rsp_err`=1 and `rsp_rdata` unchanged.
  - Next state is SETUP if a new request is accepted in the same cycle, otherwise IDLE. `psel` and `penable` deassert, or retarget, on the next edge.
- **DECERR.** Lasts one cycle, then IDLE. `rsp_valid`=1 and `rsp_err`=1 in the following cycle; `rsp_rdata` is unchanged.
- **Stability.** `paddr`, `pwrite`, `pwdata`, `pstrb` and `psel` stay stable from SETUP through the final ACCESS cycle. Request inputs are don't-care after accept.
- **Unselected slaves.** `pready`, `pslverr` and `prdata` from unselected slaves are ignored.
- **Reset mid-transfer.** `preset` in any state: the next edge forces IDLE and all outputs to reset values. The in-flight transfer produces no `rsp_valid`.

## Timing
- **Accept at edge N, zero wait states.** SETUP in cycle N+1, ACCESS in N+2 with `pready` high, `rsp_valid` in N+3. Accept-to-response latency is 3 cycles.
- **Wait states.** Each low-`pready` cycle in ACCESS adds one cycle of latency.
- **Back-to-back.** A new request accepted in the completing ACCESS cycle enters SETUP the next cycle. Peak throughput is one transfer per 2 cycles, with no IDLE gap.
- **Timeout.** The transfer is forced to end after exactly `TIMEOUT` ACCESS cycles. `rsp_valid` follows one cycle later.
- **Decode error.** `rsp_valid` is asserted 2 cycles after accept.

## Test plan
1. **Zero-wait write.** Write addr 0x0000_1010, data 0xA5A5_5A5A, strb 0xF, all `pready`=1. Required: `psel`=4'b0010 for 2 cycles, `penable` only in the 2nd, `rsp_valid` 3 cycles after accept, `rsp_err`=0.
2. **Read with wait states.** Read addr 0x0000_3004, slave 3 holds `pready` low 3 cycles, `prdata` slice 3 = 0xDEAD_BEEF. Required: ACCESS lasts 4 cycles, `rsp_rdata`=0xDEAD_BEEF, `pstrb`=0.
3. **Back-to-back with slave error.** Two back-to-back requests to slaves 0 then 2, `req_valid` held high, slave 2 returns `pslverr`=1. Required: no IDLE cycle between transfers, responses `rsp_err` 0 then 1.
4. **Timeout.** `TIMEOUT`=16, slave 1 never ready. Required: `penable` high exactly 16 cycles, then `rsp_valid`, `rsp_err`=1, `rsp_rdata` unchanged.
5. **Decode error.** `NUM_SLAVES`=3, addr 0x0000_3000. Required: `psel` stays 0, `rsp_valid` with `rsp_err`=1 two cycles after accept.
6. **Reset mid-transfer.** Assert `preset` during the 2nd wait-state cycle of a read. Required: next edge gives `psel`=0, `penable`=0, `req_ready`=0 while reset is held, and no `rsp_valid` pulse.

Source files
------------

// File: rtl/apb_multi_master.sv
// rtl/apb_multi_master.sv - valid/ready request to multi-select APB requester with timeout and decode error
module apb_multi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    state_t                  state;
    logic [7:0]              cnt;
    logic [SW-1:0]           req_idx;
    logic                    req_hit;
    logic [NUM_SLAVES-1:0]   req_onehot;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    done;
    logic                    accept;

    // The registered one-hot psel doubles as the response mux select.
    always_comb begin
        req_idx    = req_addr[SEL_LSB +: SW];
        req_hit    = (32'(req_idx) < 32'(NUM_SLAVES));
        req_onehot = NUM_SLAVES'(1) << req_idx;
        sel_ready  = |(pready & psel);
        sel_err    = |(pslverr & psel);
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel[i]) begin
                sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        done = sel_ready || (cnt == CNT_LAST);
    end

    assign req_ready = !preset && ((state == IDLE) || ((state == ACCESS) && done));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    psel    <= '0;
                    penable <= 1'b0;
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                        if (sel_ready) begin
                            rsp_err <= sel_err;
                            if (!pwrite) begin
                                rsp_rdata <= sel_rdata;
                            end
                        end else begin
                            rsp_err <= 1'b1;
                        end
                        psel    <= '0;
                        penable <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DECERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Accept only happens in IDLE or a completing ACCESS; it overrides the teardown above.
            if (accept) begin
                penable <= 1'b0;
                if (req_hit) begin
                    psel   <= req_onehot;
                    paddr  <= req_addr;
                    pwrite <= req_write;
                    pwdata <= req_wdata;
                    pstrb  <= req_write ? req_strb : STRB_W'(0);
                    state  <= SETUP;
                end else begin
                    psel  <= '0;
                    state <= DECERR;
                end
            end
        end
    end

endmodule
